// File: rtl/cntr_pkg.sv
// Shared types and helpers for the modulo up/down counter.
// Pure declarations; no logic, latency or flow control of its own.
package cntr_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  // Load values at or beyond the modulus are pulled back to the top of the range.
  function automatic int clamp_to_mod(int val, int modulus);
    return (val >= modulus) ? (modulus - 1) : val;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by PRESCALE and flags the last one with tick.
// tick is combinational from the registered phase; no backpressure, en simply freezes the phase.
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  if (PRESCALE < 1) begin : g_bad_prescale
    $fatal(1, "tick_prescaler: PRESCALE must be >= 1");
  end

  logic [W-1:0] phase_q;
  logic [W-1:0] phase_d;
  logic         at_last;

  assign at_last = (phase_q == LAST);
  assign tick    = en && !clr && at_last;

  always_comb begin
    phase_d = phase_q;
    if (clr) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = at_last ? '0 : (phase_q + ONE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/mod_updn_cntr.sv
// Modulo-MOD up/down counter with load, prescaled stepping, wrap or saturate at the limits.
// count/co/ovf update one cycle after the enabling edge, tc is combinational; always accepts input.
module mod_updn_cntr
  import cntr_pkg::*;
#(
  parameter int        N        = 4,
  parameter int        MOD      = 10,
  parameter int        PRESCALE = 1,
  parameter cnt_mode_e SAT      = CNT_WRAP
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         ld,
  input  logic         up,
  input  logic [N-1:0] din,
  output logic [N-1:0] count,
  output logic         tc,
  output logic         co,
  output logic         ovf
);

  if (MOD < 2 || MOD > (1 << N)) begin : g_bad_mod
    $fatal(1, "mod_updn_cntr: MOD must satisfy 2 <= MOD <= 2**N");
  end

  if (PRESCALE < 1) begin : g_bad_prescale
    $fatal(1, "mod_updn_cntr: PRESCALE must be >= 1");
  end

  localparam logic [N-1:0] TOP = N'(MOD - 1);
  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] count_q, count_d;
  logic         co_q, co_d;
  logic         ovf_q, ovf_d;
  logic         tick;
  logic         at_limit;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (ld),
    .tick  (tick)
  );

  // The limit depends on the current direction, so a direction flip retargets tc at once.
  assign at_limit = up ? (count_q == TOP) : (count_q == '0);

  always_comb begin
    count_d = count_q;
    co_d    = 1'b0;
    ovf_d   = ovf_q;
    if (ld) begin
      count_d = N'(clamp_to_mod(32'(din), MOD));
      ovf_d   = 1'b0;
    end else if (tick) begin
      if (!at_limit) begin
        count_d = up ? (count_q + ONE) : (count_q - ONE);
      end else if (SAT == CNT_SAT) begin
        ovf_d = 1'b1;
      end else begin
        count_d = up ? '0 : TOP;
        co_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = at_limit;
  assign co    = co_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_mod_updn_cntr.sv
// Drives four counter configurations from shared inputs and compares each against an arithmetic model.
// Instances: 0 = MOD10 wrap, 1 = MOD10 saturate, 2 = MOD10 wrap prescale 3, 3 = MOD16 wrap.
module tb_mod_updn_cntr;
  import cntr_pkg::*;

  localparam int NI = 4;
  localparam int MODS [NI] = '{10, 10, 10, 16};
  localparam int PRES [NI] = '{1, 1, 3, 1};
  localparam int SATS [NI] = '{0, 1, 0, 0};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       ld = 1'b0;
  logic       up = 1'b1;
  logic [3:0] din = 4'd0;

  logic [3:0] cnt_o [NI];
  logic       tc_o  [NI];
  logic       co_o  [NI];
  logic       ovf_o [NI];

  int m_cnt [NI];
  int m_pre [NI];
  int m_co  [NI];
  int m_ovf [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_updn_cntr #(.N(4), .MOD(10), .PRESCALE(1), .SAT(CNT_WRAP)) u_dut0 (
    .clk(clk), .reset(reset), .en(en), .ld(ld), .up(up), .din(din),
    .count(cnt_o[0]), .tc(tc_o[0]), .co(co_o[0]), .ovf(ovf_o[0]));
  mod_updn_cntr #(.N(4), .MOD(10), .PRESCALE(1), .SAT(CNT_SAT)) u_dut1 (
    .clk(clk), .reset(reset), .en(en), .ld(ld), .up(up), .din(din),
    .count(cnt_o[1]), .tc(tc_o[1]), .co(co_o[1]), .ovf(ovf_o[1]));
  mod_updn_cntr #(.N(4), .MOD(10), .PRESCALE(3), .SAT(CNT_WRAP)) u_dut2 (
    .clk(clk), .reset(reset), .en(en), .ld(ld), .up(up), .din(din),
    .count(cnt_o[2]), .tc(tc_o[2]), .co(co_o[2]), .ovf(ovf_o[2]));
  mod_updn_cntr #(.N(4), .MOD(16), .PRESCALE(1), .SAT(CNT_WRAP)) u_dut3 (
    .clk(clk), .reset(reset), .en(en), .ld(ld), .up(up), .din(din),
    .count(cnt_o[3]), .tc(tc_o[3]), .co(co_o[3]), .ovf(ovf_o[3]));

  // Reference: prescale phase counts enabled cycles; a step moves by +/-1 and
  // resolves out-of-range results by wrapping (mod arithmetic) or refusing.
  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      int target;
      if (reset) begin
        m_cnt[i] = 0; m_pre[i] = 0; m_co[i] = 0; m_ovf[i] = 0;
      end else if (ld) begin
        m_cnt[i] = (int'(din) >= MODS[i]) ? MODS[i] - 1 : int'(din);
        m_pre[i] = 0; m_co[i] = 0; m_ovf[i] = 0;
      end else if (en) begin
        m_co[i]  = 0;
        m_pre[i] = m_pre[i] + 1;
        if (m_pre[i] == PRES[i]) begin
          m_pre[i] = 0;
          target = up ? m_cnt[i] + 1 : m_cnt[i] - 1;
          if (target >= 0 && target < MODS[i]) begin
            m_cnt[i] = target;
          end else if (SATS[i] == 1) begin
            m_ovf[i] = 1;
          end else begin
            m_cnt[i] = (target + MODS[i]) % MODS[i];
            m_co[i]  = 1;
          end
        end
      end else begin
        m_co[i] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      int exp_tc;
      exp_tc = up ? int'(m_cnt[i] == MODS[i] - 1) : int'(m_cnt[i] == 0);
      chk($sformatf("count%0d", i), 32'(cnt_o[i]), m_cnt[i]);
      chk($sformatf("tc%0d", i),    32'(tc_o[i]),  exp_tc);
      chk($sformatf("co%0d", i),    32'(co_o[i]),  m_co[i]);
      chk($sformatf("ovf%0d", i),   32'(ovf_o[i]), m_ovf[i]);
    end
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_all();
    end
  endtask

  initial begin
    // Reset state
    reset = 1'b1; en = 1'b0; ld = 1'b0; up = 1'b1; din = 4'd0;
    cyc(2);
    chk("rst_count0", 32'(cnt_o[0]), 0);

    // Free-running up count with wrap
    reset = 1'b0; en = 1'b1; up = 1'b1;
    cyc(9);
    chk("up_nine", 32'(cnt_o[0]), 9);
    chk("up_tc_at_nine", 32'(tc_o[0]), 1);
    cyc(1);
    chk("up_wrap_zero", 32'(cnt_o[0]), 0);
    chk("up_wrap_co", 32'(co_o[0]), 1);
    cyc(1);
    chk("up_co_one_cycle", 32'(co_o[0]), 0);

    // Clamped load then count down through the wrap
    ld = 1'b1; din = 4'd13;
    cyc(1);
    chk("ld_clamp_mod10", 32'(cnt_o[0]), 9);
    chk("ld_no_clamp_mod16", 32'(cnt_o[3]), 13);
    ld = 1'b0; up = 1'b0;
    cyc(9);
    chk("dn_zero", 32'(cnt_o[0]), 0);
    cyc(1);
    chk("dn_wrap_nine", 32'(cnt_o[0]), 9);
    chk("dn_wrap_co", 32'(co_o[0]), 1);

    // Saturation at the top
    ld = 1'b1; din = 4'd9;
    cyc(1);
    ld = 1'b0; up = 1'b1;
    cyc(3);
    chk("sat_hold", 32'(cnt_o[1]), 9);
    chk("sat_ovf", 32'(ovf_o[1]), 1);
    chk("sat_no_co", 32'(co_o[1]), 0);
    ld = 1'b1; din = 4'd2;
    cyc(1);
    chk("sat_reload", 32'(cnt_o[1]), 2);
    chk("sat_ovf_clr", 32'(ovf_o[1]), 0);
    ld = 1'b0;

    // Prescaled stepping with an enable gap mid-prescale
    reset = 1'b1;
    cyc(1);
    reset = 1'b0; en = 1'b1; up = 1'b1;
    cyc(2);
    chk("ps_no_step_yet", 32'(cnt_o[2]), 0);
    cyc(1);
    chk("ps_first_step", 32'(cnt_o[2]), 1);
    cyc(1);
    en = 1'b0;
    cyc(2);
    en = 1'b1;
    cyc(1);
    chk("ps_gap_delayed", 32'(cnt_o[2]), 1);
    cyc(1);
    chk("ps_gap_step", 32'(cnt_o[2]), 2);

    // Simultaneous events: reset beats load; load beats a pending tick
    reset = 1'b1; ld = 1'b1; din = 4'd5;
    cyc(1);
    chk("rst_over_ld", 32'(cnt_o[0]), 0);
    reset = 1'b0; ld = 1'b0; en = 1'b1;
    cyc(2);
    ld = 1'b1; din = 4'd5;
    cyc(1);
    chk("ld_over_tick", 32'(cnt_o[2]), 5);
    ld = 1'b0;
    cyc(2);
    chk("ld_clears_prescale", 32'(cnt_o[2]), 5);
    cyc(1);
    chk("ld_then_step", 32'(cnt_o[2]), 6);

    // Full binary modulus wrap both ways
    ld = 1'b1; din = 4'd15; up = 1'b1;
    cyc(1);
    ld = 1'b0;
    cyc(1);
    chk("m16_up_wrap", 32'(cnt_o[3]), 0);
    chk("m16_up_co", 32'(co_o[3]), 1);
    up = 1'b0;
    cyc(1);
    chk("m16_dn_wrap", 32'(cnt_o[3]), 15);
    chk("m16_dn_co", 32'(co_o[3]), 1);

    // Random traffic
    for (int r = 0; r < 800; r++) begin
      reset = ($urandom_range(0, 99) < 2);
      ld    = ($urandom_range(0, 99) < 6);
      en    = ($urandom_range(0, 99) < 80);
      if ($urandom_range(0, 99) < 15) up = ~up;
      din   = 4'($urandom_range(0, 15));
      cyc(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_updn_cntr.md
MOD_UPDN_CNTR -- requirements
Module: mod_updn_cntr

Interface
REQ-001 Parameter N, default 4: counter width in bits.
REQ-002 Parameter MOD, default 10: modulus; the count range is 0..MOD-1.
REQ-003 Parameter PRESCALE, default 1: number of enabled cycles per count step.
REQ-004 Parameter SAT, default 0: 0 selects wrap mode, 1 selects saturate mode.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 en  input  1  count enable; gates both the prescaler and stepping.
REQ-008 ld  input  1  synchronous parallel load of din.
REQ-009 up  input  1  direction: 1 counts up, 0 counts down.
REQ-010 din  input  N  load value.
REQ-011 count  output  N  current count, registered.
REQ-012 tc  output  1  terminal count, combinational.
- up=1: asserted when count==MOD-1.
- up=0: asserted when count==0.
REQ-013 co  output  1  registered one-cycle carry/borrow pulse on wrap.
REQ-014 ovf  output  1  registered sticky flag for a step attempted at a limit in saturate mode.

Function
REQ-015 Priority per edge SHALL be reset > ld > step > hold.
REQ-016 Load behaviour:
- ld=1 loads count<=din, regardless of en or prescaler state.
- din>=MOD is clamped to MOD-1.
- Load clears the prescaler to 0, clears ovf, and drives co<=0.
REQ-017 Prescaler:
- Increments on each cycle with en=1 and ld=0.
- Asserts an internal tick when its value is PRESCALE-1, then returns to 0.
- With en=0 it holds its value.
- PRESCALE=1 gives a tick on every enabled cycle.
REQ-018 A step occurs only on a cycle with en=1, tick=1 and ld=0; otherwise count holds and co<=0.
REQ-019 Non-limit step: count<=count+1 (up=1) or count<=count-1 (up=0); co<=0.
REQ-020 Wrap mode (SAT=0), limit reached:
- Up-step at MOD-1 gives count<=0.
- Down-step at 0 gives count<=MOD-1.
- co<=1 for exactly the following cycle.
REQ-021 Saturate mode (SAT=1), limit reached:
- Up-step at MOD-1 or down-step at 0 holds count.
- Sets ovf<=1, which stays set until ld or reset.
- co never asserts in this mode.
REQ-022 A direction change takes effect on the next step, with no extra latency; tc follows up combinationally in the same cycle.
REQ-023 Arithmetic SHALL be N bits wide, with no intermediate overflow for any legal MOD.
REQ-024 Legal MOD values are 2 <= MOD <= 2**N; an illegal MOD SHALL fail elaboration.
REQ-025 A legal PRESCALE value is PRESCALE >= 1; an illegal PRESCALE SHALL fail elaboration.

Reset
REQ-026 With reset=1 at an edge, the block SHALL set count<=0, prescaler<=0, co<=0 and ovf<=0, overriding ld and en.
REQ-027 Reset mid-prescale SHALL discard the partial prescale count; the first step after reset requires PRESCALE enabled cycles.

Structure
REQ-028 A shared package cntr_pkg SHALL hold the mode typedef (CNT_WRAP, CNT_SAT) and a clamp helper function; SAT is typed from this package.
REQ-029 The prescaler SHALL be a sub-module tick_prescaler, with parameter PRESCALE, inputs clk, reset, en, clr and output tick.
REQ-030 All outputs except tc SHALL be flops; there SHALL be no latches and no other clocks.

Verification
REQ-031 N=4, MOD=10, SAT=0, PRESCALE=1, up=1, en=1 from reset: count runs 0..9,0; tc=1 at 9; co=1 for one cycle with count=0.
REQ-032 Same configuration, ld=1 with din=4'd13: count=9 next cycle; then up=0 for 10 steps yields 8..0,9, with co pulsing once at 9.
REQ-033 SAT=1, count=9, up=1, en=1 for 3 cycles: count stays 9, ovf=1 and co=0; then ld with din=2 gives count=2 and ovf=0.
REQ-034 PRESCALE=3: en=1 gives one step every 3 cycles; en=0 for 2 cycles mid-prescale delays the step by exactly 2 cycles.
REQ-035 Simultaneous events:
- reset=1 with ld=1, din=5 gives count=0.
- ld=1 with a pending tick gives count=din and no step.
REQ-036 N=4, MOD=16, SAT=0: up from 15 wraps to 0 with co=1; down from 0 wraps to 15 with co=1.
